conv_axi_mem: RTL

Word-addressed burst memory slave that sits directly on the convolution engine's AXI-style master port. It serves the engine's 16 read bursts of 256 beats over the input image (word addresses 0x0000-0x0FFF). It also absorbs the engine's interleaved write bursts: 128-beat layer-0 bursts at 0x1000+ and 32-beat layer-1 bursts at 0x2000+. Read and write channels run independently. A host port preloads images and inspects results.

---
 rtl/conv_axi_mem_if.sv | 29 ++
 rtl/conv_axi_mem.sv | 135 +++++++++++++
 2 files changed

// File: rtl/conv_axi_mem_if.sv
// AXI-style burst channels between the convolution engine (master) and conv_axi_mem (slave).
interface conv_axi_mem_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic              RVALID;
    logic              RREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic              AWVALID;
    logic              AWREADY;
    logic [31:0]       WDATA;
    logic              WVALID;
    logic              WREADY;

    modport master (
        output ARADDR, ARLEN, ARVALID, RREADY, AWADDR, AWLEN, AWVALID, WDATA, WVALID,
        input  ARREADY, RDATA, RVALID, AWREADY, WREADY
    );

    modport slave (
        input  ARADDR, ARLEN, ARVALID, RREADY, AWADDR, AWLEN, AWVALID, WDATA, WVALID,
        output ARREADY, RDATA, RVALID, AWREADY, WREADY
    );
endinterface

// File: rtl/conv_axi_mem.sv
// Word-addressed burst memory slave with independent read/write FSMs and a host port.
// Optional MEM_STALL_EN: LFSR-driven random stalls on RVALID / WREADY.
module conv_axi_mem #(
    parameter int          ADDR_W    = 14,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_axi_mem_if.slave     axi,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic [31:0]       host_rdata
);
    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    typedef enum logic       {R_IDLE, R_BURST}         r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} w_state_e;

    logic [31:0] mem [DEPTH];

    r_state_e          r_state, r_next;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        rcnt;
    logic [31:0]       rdata_q;
    logic              arready_q, rvalid_q;

    w_state_e          w_state, w_next;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wcnt;
    logic              awready_q, wready_q;

    // Stall decision is taken from the next LFSR value so the valid/ready flops stay pure registers.
    logic stall_next;
`ifdef MEM_STALL_EN
    logic [15:0] lfsr, lfsr_next;
    assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign stall_next = (lfsr_next[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_next;
    end
`else
    logic [15:0] unused_seed;
    assign unused_seed = LFSR_SEED;
    assign stall_next  = 1'b0;
`endif

    logic ar_fire, r_fire, aw_fire, w_fire;
    assign ar_fire = axi.ARVALID & arready_q;
    assign r_fire  = rvalid_q & axi.RREADY;
    assign aw_fire = axi.AWVALID & awready_q;
    assign w_fire  = axi.WVALID & wready_q;

    assign axi.ARREADY = arready_q;
    assign axi.RVALID  = rvalid_q;
    assign axi.RDATA   = rdata_q;
    assign axi.AWREADY = awready_q;
    assign axi.WREADY  = wready_q;
    assign host_rdata  = mem[host_addr];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_next = R_BURST;
            R_BURST: if (r_fire && rcnt == 8'd0) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            raddr     <= '0;
            rcnt      <= '0;
            rdata_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            rvalid_q  <= (r_next == R_BURST) && !stall_next;
            if (ar_fire) begin
                raddr   <= axi.ARADDR;
                rcnt    <= axi.ARLEN;
                rdata_q <= mem[axi.ARADDR];
            end else if (r_fire && rcnt != 8'd0) begin
                raddr   <= raddr + A_ONE;
                rcnt    <= rcnt - 8'd1;
                rdata_q <= mem[raddr + A_ONE];
            end
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_next = W_BURST;
            W_BURST: if (w_fire && wcnt == 8'd0) w_next = W_RESP;
            W_RESP:  w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            waddr     <= '0;
            wcnt      <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE);
            wready_q  <= (w_next == W_BURST) && !stall_next;
            if (aw_fire) begin
                waddr <= axi.AWADDR;
                wcnt  <= axi.AWLEN;
            end else if (w_fire && wcnt != 8'd0) begin
                waddr <= waddr + A_ONE;
                wcnt  <= wcnt - 8'd1;
            end
        end
    end

    // NOTE: the array has no reset so contents survive rst_n; the later host write wins a same-address clash.
    always_ff @(posedge clk) begin
        if (w_fire)  mem[waddr]     <= axi.WDATA;
        if (host_we) mem[host_addr] <= host_wdata;
    end
endmodule
